// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mdu_pkg;

   // Operation codes; 10-15 are no-ops.
   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MADD  = 4'd4;
   localparam logic [3:0] OP_MADDU = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd6;
   localparam logic [3:0] OP_MSUBU = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MUL     = 2'd1,
      S_DIV_RUN = 2'd2,
      S_DIV_FIX = 2'd3
   } mdu_state_t;

   // Number of DIV_RUN cycles: DIV_ITERS = WIDTH / DIV_STEP.
   function automatic int unsigned div_iters(input int unsigned width,
                                             input int unsigned step);
      return width / step;
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One iteration of restoring division, resolving DIV_STEP quotient bits.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DIV_STEP = 4
) (
   input  logic [WIDTH-1:0]    rem_i,
   input  logic [DIV_STEP-1:0] dvd_bits,
   input  logic [WIDTH-1:0]    dsr,
   output logic [WIDTH-1:0]    rem_o,
   output logic [DIV_STEP-1:0] q_o
);

   logic [WIDTH:0] r;

   // Shift in dividend bits MSB first; subtract divisor whenever it fits.
   always_comb begin
      r    = {1'b0, rem_i};
      q_o  = '0;
      for (int i = DIV_STEP - 1; i >= 0; i--) begin
         r = {r[WIDTH-1:0], dvd_bits[i]};
         if (r >= {1'b0, dsr}) begin
            r      = r - {1'b0, dsr};
            q_o[i] = 1'b1;
         end
      end
      rem_o = r[WIDTH-1:0];
   end

endmodule

// File: rtl/e_mdu_param.sv
// Execute-stage multiply/divide unit with its own HI/LO pair.
module e_mdu_param
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_LAT  = 5,
   parameter int unsigned DIV_STEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned DIV_ITERS = div_iters(WIDTH, DIV_STEP);
   localparam int unsigned CNT_MAX   = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
   localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam int unsigned PW        = 2 * WIDTH;

   mdu_state_t           state_q, state_d;
   logic                 busy_d;
   logic [WIDTH-1:0]     hi_d, lo_d;
   logic [3:0]           op_q, op_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]        prod_q, prod_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d;
   logic [WIDTH-1:0]     dsr_q, dsr_d;
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;
   logic                 q_neg_q, q_neg_d;
   logic                 r_neg_q, r_neg_d;
   logic                 dz_q, dz_d;

   logic                 mul_sgn;
   logic                 div_sgn;
   logic [PW-1:0]        a_ext, b_ext, prod_new, hilo, quo_c;
   logic [WIDTH-1:0]     step_rem;
   logic [DIV_STEP-1:0]  step_q;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign mul_sgn  = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   assign div_sgn  = (op == OP_DIV);
   assign a_ext    = mul_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext    = mul_sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod_new = a_ext * b_ext;
   assign hilo     = {hi, lo};
   assign quo_c    = {{WIDTH{1'b0}}, dvd_q};
   assign quo_fix  = q_neg_q ? (WIDTH'(0) - quo_c[WIDTH-1:0]) : quo_c[WIDTH-1:0];
   assign rem_fix  = r_neg_q ? (WIDTH'(0) - rem_q) : rem_q;

   mdu_div_step #(
      .WIDTH    (WIDTH),
      .DIV_STEP (DIV_STEP)
   ) u_div_step (
      .rem_i    (rem_q),
      .dvd_bits (dvd_q[WIDTH-1 -: DIV_STEP]),
      .dsr      (dsr_q),
      .rem_o    (step_rem),
      .q_o      (step_q)
   );

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      busy_d  = busy;
      hi_d    = hi;
      lo_d    = lo;
      op_d    = op_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      a_raw_d = a_raw_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;

      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     op_d    = op;
                     prod_d  = prod_new;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     op_d    = op;
                     dvd_d   = (div_sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
                     dsr_d   = (div_sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
                     rem_d   = '0;
                     a_raw_d = a;
                     q_neg_d = div_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_neg_d = div_sgn && a[WIDTH-1];
                     dz_d    = (b == '0);
                     cnt_d   = CNT_W'(DIV_ITERS - 1);
                     state_d = S_DIV_RUN;
                     busy_d  = 1'b1;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end

         S_MUL: begin
            if (cancel) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q == '0) begin
               case (op_q)
                  OP_MADD, OP_MADDU: {hi_d, lo_d} = hilo + prod_q;
                  OP_MSUB, OP_MSUBU: {hi_d, lo_d} = hilo - prod_q;
                  default:           {hi_d, lo_d} = prod_q;
               endcase
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_DIV_RUN: begin
            if (cancel) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               rem_d = step_rem;
               dvd_d = {dvd_q[WIDTH-DIV_STEP-1:0], step_q};
               if (cnt_q == '0) begin
                  state_d = S_DIV_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         S_DIV_FIX: begin
            if (!cancel) begin
               if (dz_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, architectural HI/LO and operand registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         a_raw_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         hi      <= hi_d;
         lo      <= lo_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         a_raw_q <= a_raw_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_e_mdu_param.sv
// Directed, table-driven bench for e_mdu_param (default build plus a DIV_STEP=1 build).
module tb_e_mdu_param;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start, cancel;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   logic        s_start, s_cancel;
   logic [3:0]  s_op;
   logic [31:0] s_a, s_b;
   logic        s_busy;
   logic [31:0] s_hi, s_lo;

   int checks;
   int failures;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   e_mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_STEP(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
   );

   e_mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_STEP(1)) dut_s1 (
      .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
      .cancel(s_cancel), .busy(s_busy), .hi(s_hi), .lo(s_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input string nm, input logic [3:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input int el_lat);
      vecs[idx].name = nm;
      vecs[idx].op   = o;
      vecs[idx].a    = va;
      vecs[idx].b    = vb;
      vecs[idx].hi   = eh;
      vecs[idx].lo   = el;
      vecs[idx].lat  = el_lat;
   endtask

   // Issue one op, count busy cycles (bounded), then compare latency and HI/LO.
   task automatic run_op(input bit sel, input string nm, input logic [3:0] o,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eh, input logic [31:0] el, input int el_lat);
      int lat;
      @(negedge clk);
      if (sel) begin s_start = 1'b1; s_op = o; s_a = va; s_b = vb; end
      else     begin start   = 1'b1; op   = o; a   = va; b   = vb; end
      @(negedge clk);
      start   = 1'b0;
      s_start = 1'b0;
      lat = 0;
      while ((sel ? s_busy : busy) && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      check({nm, "_lat"}, 32'(lat), 32'(el_lat));
      check({nm, "_hi"}, sel ? s_hi : hi, eh);
      check({nm, "_lo"}, sel ? s_lo : lo, el);
   endtask

   initial begin
      int lat;
      checks   = 0;
      failures = 0;
      reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd0; a = '0; b = '0;
      s_start = 1'b0; s_cancel = 1'b0; s_op = 4'd0; s_a = '0; s_b = '0;

      set_vec(0,  "mult",       OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      set_vec(1,  "multu",      OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5);
      set_vec(2,  "divu",       OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       9);
      set_vec(3,  "div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 9);
      set_vec(4,  "div_zero",   OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 9);
      set_vec(5,  "div_minm1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 9);
      set_vec(6,  "mthi",       OP_MTHI,  32'd0,        32'd0,        32'd0,        32'h80000000, 0);
      set_vec(7,  "mtlo",       OP_MTLO,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0);
      set_vec(8,  "maddu",      OP_MADDU, 32'd1,        32'd1,        32'd1,        32'd0,        5);
      set_vec(9,  "msub",       OP_MSUB,  32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 5);
      set_vec(10, "nop10",      4'd10,    32'h12345678, 32'd9,        32'd0,        32'hFFFFFFFF, 0);
      set_vec(11, "msubu_wrap", OP_MSUBU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h00000001, 5);
      set_vec(12, "madd_neg",   OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 5);
      set_vec(13, "div_negdsr", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 9);
      set_vec(14, "divu_zero",  OP_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 9);
      set_vec(15, "div_zero_n", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 9);

      // Reset state
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_op(1'b0, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].lat);
      end

      // Cancel on the 4th busy cycle of a DIV: hi/lo keep FFFFFFF9/FFFFFFFF
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("cancel_busy_before", 32'(busy), 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("cancel_busy_hold", 32'(busy), 32'd0);
      check("cancel_hi", hi, 32'hFFFFFFF9);
      check("cancel_lo", lo, 32'hFFFFFFFF);

      // Start while busy is ignored
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      @(negedge clk);
      op = OP_MULT; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (busy && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      check("ignore_lat", 32'(lat), 32'd9);
      check("ignore_hi", hi, 32'd2);
      check("ignore_lo", lo, 32'd14);
      @(negedge clk);
      check("ignore_noqueue", 32'(busy), 32'd0);

      // Cancel and start in the same cycle
      start = 1'b1; cancel = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("cs_busy", 32'(busy), 32'd0);
      start = 1'b1; cancel = 1'b1; op = OP_MTHI; a = 32'h1234;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      check("cs_busy2", 32'(busy), 32'd0);
      check("cs_hi", hi, 32'd2);
      check("cs_lo", lo, 32'd14);

      // Asynchronous reset mid-MULT
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op(1'b0, "post_rst_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);

      // DIV_STEP=1 build
      run_op(1'b1, "s1_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      run_op(1'b1, "s1_div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op(1'b1, "s1_div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
